parity_burst_tx: RTL
====================

PARITY_BURST_TX -- requirements
Module: parity_burst_tx

Interface
REQ-001 Parameter: SEED, 8'hA5, reload value of the internal 8-bit LFSR; SEED SHALL be nonzero.
REQ-002 Port: clk  in  1  rising-edge clock.
REQ-003 Port: reset  in  1  synchronous, active-low reset.
REQ-004 Port: start  in  1  burst request, sampled only in IDLE.
REQ-005 Port: len  in  4  number of odd-parity words in the burst, 0..15, sampled with start.
REQ-006 Port: w1, w2, w3  out  1 each  registered 3-line word toward the consecutive-odd-parity detector.
REQ-007 Port: busy  out  1  high while in SEND or TERM.
REQ-008 Port: done  out  1  one-cycle pulse coincident with the terminator word.
REQ-009 Port: z_exp  out  1  registered model of detector output z, for scoreboarding.

Function
REQ-010 The FSM SHALL have three states: IDLE, SEND and TERM.
REQ-011 In IDLE with start=1 and len!=0, the FSM SHALL load cnt=len and enter SEND at the next edge.
REQ-012 In IDLE with start=1 and len=0, the FSM SHALL enter TERM directly.
REQ-013 In IDLE with start=0, the FSM SHALL stay in IDLE.
REQ-014 Each SEND cycle SHALL drive one odd-parity word and decrement cnt; when cnt=1 the next state SHALL be TERM.
REQ-015 TERM SHALL last exactly one cycle, drive one even-parity word, assert done, then return to IDLE.
REQ-016 Word generation: w1=lfsr[0], w2=lfsr[1]; w3=~(w1^w2) in SEND (odd parity), w3=(w1^w2) in TERM (even parity).
REQ-017 The LFSR SHALL be 8 bits, Fibonacci, polynomial x^8+x^6+x^5+x^4+1, and SHALL advance once per SEND/TERM cycle only.
REQ-018 In IDLE, w1/w2/w3 SHALL be 0.
REQ-019 All outputs SHALL be registered, so the first burst word appears in the cycle after start is sampled.
REQ-020 start in SEND or TERM SHALL be ignored, with no queuing; a new start is accepted in the first IDLE cycle after TERM.
REQ-021 A run counter (0..3, saturating) SHALL update each edge: increment on an odd-parity word on w1..w3, clear on an even-parity word.
REQ-022 z_exp SHALL be (run==3), so it matches the detector's z timing.
REQ-023 busy SHALL be low in IDLE, and high in SEND and TERM.

Reset
REQ-024 When reset=0 at a clock edge, the next cycle SHALL show state=IDLE, cnt=0, run=0, lfsr=SEED, and w1=w2=w3=busy=done=z_exp=0.
REQ-025 Reset mid-burst SHALL abort the burst with no terminator and no done pulse.
REQ-026 Reset SHALL take priority over start in the same cycle.

Structure
REQ-027 A shared package SHALL hold: the state encoding (IDLE=2'b00, SEND=2'b01, TERM=2'b10), the LFSR width, the tap mask, and the run saturation value 3.
REQ-028 The LFSR SHALL be a sub-module lfsr8 with ports clk, reset, adv and q[7:0], and a SEED parameter.
REQ-029 The FSM, counter, run model and output registers SHALL reside in parity_burst_tx.

Verification
REQ-030 Scenario: start with len=5 in cycle 0 -> odd words in cycles 1-5, even word plus done in cycle 6, busy high cycles 1-6, z_exp high cycles 4-6, and z_exp low from cycle 7.
REQ-031 Scenario: len=2 -> odd words in cycles 1-2, terminator in cycle 3, z_exp never asserted.
REQ-032 Scenario: len=0 -> terminator plus done in cycle 1, busy high for cycle 1 only, z_exp low throughout.
REQ-033 Scenario: len=15 with start held high throughout -> exactly one burst (15 odd words plus 1 terminator), then a second burst starting in the first IDLE cycle after TERM.
REQ-034 Scenario: reset=0 in cycle 3 of a len=8 burst -> all outputs 0 from cycle 4 and no done; rerunning len=8 reproduces the first burst's word sequence bit-for-bit.
REQ-035 Scenario: connect the consecutive-odd-parity detector downstream -> its z SHALL equal z_exp every cycle across 1000 random start/len stimuli.

Source files
------------

// File: rtl/parity_burst_tx_pkg.sv
// Shared definitions for the parity burst transmitter: state encoding,
// LFSR geometry and the run-length saturation point of the detector model.
package parity_burst_tx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SEND = 2'b01,
        TERM = 2'b10
    } state_t;

    localparam int          LFSR_W    = 8;
    localparam int          LEN_W     = 4;
    // x^8 + x^6 + x^5 + x^4 + 1 -> feedback from bits 7, 5, 4, 3
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;
    localparam logic [1:0]  RUN_SAT   = 2'd3;

    function automatic logic odd_parity(input logic [2:0] w);
        return ^w;
    endfunction

endpackage

// File: rtl/parity_burst_tx_lfsr8.sv
// 8-bit Fibonacci LFSR that steps only when adv is high; reloads SEED on reset.
module lfsr8
    import parity_burst_tx_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              adv,
    output logic [LFSR_W-1:0] q
);

    // SEED must be nonzero, otherwise the register locks up at all-zeros.
    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= SEED;
        end else if (adv) begin
            q <= {q[LFSR_W-2:0], ^(q & LFSR_TAPS)};
        end
    end

endmodule

// File: rtl/parity_burst_tx.sv
// Burst generator feeding a consecutive-odd-parity detector: len odd-parity
// words followed by one even-parity terminator, plus a registered model of z.
module parity_burst_tx
    import parity_burst_tx_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 8'hA5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             w1,
    output logic             w2,
    output logic             w3,
    output logic             busy,
    output logic             done,
    output logic             z_exp
);

    state_t             state, state_nxt;
    logic [LEN_W-1:0]   cnt, cnt_nxt;
    logic [1:0]         run, run_nxt;
    logic [LFSR_W-1:0]  lfsr_q;
    logic               lfsr_adv;
    logic               lfsr_unused;
    logic [2:0]         word_nxt;
    logic               a, b;

    lfsr8 #(
        .SEED (SEED)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .adv   (lfsr_adv),
        .q     (lfsr_q)
    );

    assign lfsr_unused = ^lfsr_q[LFSR_W-1:2];
    assign a           = lfsr_q[0];
    assign b           = lfsr_q[1];

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        state_nxt = SEND;
                        cnt_nxt   = len;
                    end else begin
                        state_nxt = TERM;
                    end
                end
            end
            SEND: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_nxt = TERM;
                end
            end
            TERM: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state, so they line up with it.
    always_comb begin
        lfsr_adv = (state_nxt != IDLE);
        word_nxt = 3'b000;
        case (state_nxt)
            SEND:    word_nxt = {a, b, ~(a ^ b)};
            TERM:    word_nxt = {a, b, (a ^ b)};
            default: word_nxt = 3'b000;
        endcase
    end

    always_comb begin
        run_nxt = 2'd0;
        if (odd_parity({w1, w2, w3})) begin
            run_nxt = (run == RUN_SAT) ? RUN_SAT : run + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            run   <= 2'd0;
            w1    <= 1'b0;
            w2    <= 1'b0;
            w3    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            z_exp <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            run          <= run_nxt;
            {w1, w2, w3} <= word_nxt;
            busy         <= (state_nxt != IDLE);
            done         <= (state_nxt == TERM);
            z_exp        <= (run_nxt == RUN_SAT);
        end
    end

endmodule
